// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, register offsets and glyph table
// for the seg7_sb_ctrl display slave.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam logic [31:0] DIGIT_BASE = 32'h0000_0000;
  localparam logic [31:0] EN_ADDR    = 32'h0000_0040;
  localparam logic [31:0] BLINK_ADDR = 32'h0000_0044;
  localparam logic [31:0] CTRL_ADDR  = 32'h0000_0048;

  // Active-low {g,f,e,d,c,b,a}
  function automatic seg_t hex_to_seg(input logic [3:0] v);
    seg_t s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_sb_ctrl_if.sv
// seg7_sb_ctrl_if: peripheral bus port shared by the *_sb_ctrl slaves.
// Single-cycle request, read data one cycle later.
interface seg7_sb_ctrl_if;
  logic        req_i;
  logic        write_enable_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;

  modport master (
    output req_i,
    output write_enable_i,
    output addr_i,
    output write_data_i,
    input  read_data_o
  );

  modport slave (
    input  req_i,
    input  write_enable_i,
    input  addr_i,
    input  write_data_i,
    output read_data_o
  );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: slot/frame/blink counters and the registered
// segment/anode drivers for the digit currently in its slot.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 1024,
  parameter int BLINK_DIV = 512
) (
  input  logic                   clk_i,
  input  logic                   rst,
  input  logic [DIGITS-1:0][4:0] dig,
  input  logic [DIGITS-1:0]      en,
  input  logic [DIGITS-1:0]      blink,
  output seg_t                   hex_led_o,
  output logic                   hex_dp_o,
  output logic [DIGITS-1:0]      hex_sel_o
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_ph;
  logic          slot_end, frame_end, blink_end;
  logic [4:0]    cur;
  logic          vis;

  assign slot_end  = scan_cnt == SW'(SCAN_DIV - 1);
  assign frame_end = slot_end && idx == IW'(DIGITS - 1);
  assign blink_end = frame_cnt == FW'(BLINK_DIV - 1);

  always_comb begin
    cur = '0;
    vis = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur = dig[k];
        vis = en[k] && !(blink[k] && blink_ph);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      scan_cnt  <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      scan_cnt <= slot_end ? '0 : scan_cnt + 1'b1;
      if (slot_end)
        idx <= frame_end ? '0 : idx + 1'b1;
      if (frame_end) begin
        frame_cnt <= blink_end ? '0 : frame_cnt + 1'b1;
        if (blink_end)
          blink_ph <= ~blink_ph;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst || !vis) begin
      hex_sel_o <= '1;
      hex_led_o <= 7'h7F;
      hex_dp_o  <= 1'b1;
    end else begin
      hex_sel_o <= ~(DIGITS'(1) << idx);
      hex_led_o <= hex_to_seg(cur[3:0]);
      hex_dp_o  <= ~cur[4];
    end
  end

endmodule

// File: rtl/seg7_sb_ctrl.sv
// seg7_sb_ctrl: bus slave for a multiplexed 7-segment display.
// Bus decode, register file and read mux; scanning is in seg7_scan.
module seg7_sb_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 1024,
  parameter int BLINK_DIV = 512
) (
  input  logic              clk_i,
  input  logic              rst,
  seg7_sb_ctrl_if.slave     bus,
  output seg_t              hex_led_o,
  output logic              hex_dp_o,
  output logic [DIGITS-1:0] hex_sel_o
);
  logic [DIGITS-1:0][4:0] dig_q;
  logic [DIGITS-1:0]      en_q, blink_q;
  logic                   wr, rd, aligned;
  logic                   dig_hit, en_hit, blink_hit, ctrl_hit;
  logic                   soft_rst;
  logic [4:0]             dig_rd;
  logic [31:0]            rd_d;

  assign wr      = bus.req_i && bus.write_enable_i;
  assign rd      = bus.req_i && !bus.write_enable_i;
  assign aligned = bus.addr_i[1:0] == 2'b00;

  assign dig_hit = aligned
    && bus.addr_i[31:6] == DIGIT_BASE[31:6]
    && {28'd0, bus.addr_i[5:2]} < 32'(DIGITS);
  assign en_hit    = bus.addr_i == EN_ADDR;
  assign blink_hit = bus.addr_i == BLINK_ADDR;
  assign ctrl_hit  = bus.addr_i == CTRL_ADDR;
  assign soft_rst  = wr && ctrl_hit && bus.write_data_i[0];

  always_comb begin
    dig_rd = '0;
    for (int k = 0; k < DIGITS; k++)
      if (bus.addr_i[5:2] == 4'(k))
        dig_rd = dig_q[k];
  end

  always_ff @(posedge clk_i) begin
    if (rst || soft_rst) begin
      dig_q   <= '0;
      en_q    <= '1;
      blink_q <= '0;
    end else if (wr) begin
      for (int k = 0; k < DIGITS; k++)
        if (dig_hit && bus.addr_i[5:2] == 4'(k))
          dig_q[k] <= bus.write_data_i[4:0];
      if (en_hit)
        en_q <= bus.write_data_i[DIGITS-1:0];
      if (blink_hit)
        blink_q <= bus.write_data_i[DIGITS-1:0];
    end
  end

  always_comb begin
    rd_d = '0;
    unique case (1'b1)
      dig_hit:   rd_d = {27'd0, dig_rd};
      en_hit:    rd_d = 32'(en_q);
      blink_hit: rd_d = 32'(blink_q);
      default:   rd_d = '0;
    endcase
  end

  // Soft reset leaves the last read result on the bus
  always_ff @(posedge clk_i) begin
    if (rst)
      bus.read_data_o <= '0;
    else if (rd)
      bus.read_data_o <= rd_d;
  end

  seg7_scan #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) u_scan (
    .clk_i     (clk_i),
    .rst       (rst || soft_rst),
    .dig       (dig_q),
    .en        (en_q),
    .blink     (blink_q),
    .hex_led_o (hex_led_o),
    .hex_dp_o  (hex_dp_o),
    .hex_sel_o (hex_sel_o)
  );

endmodule

// File: tb/tb_seg7_sb_ctrl.sv
// tb_seg7_sb_ctrl: randomized bench for seg7_sb_ctrl against a
// position-arithmetic reference model of the display.
module tb_seg7_sb_ctrl;
  localparam int DG = 4;
  localparam int SD = 4;
  localparam int BD = 2;

  logic          clk_i = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    hex_led_o;
  logic          hex_dp_o;
  logic [DG-1:0] hex_sel_o;
  int            n_tests = 0;
  int            n_fail = 0;

  seg7_sb_ctrl_if bus();

  seg7_sb_ctrl #(
    .DIGITS    (DG),
    .SCAN_DIV  (SD),
    .BLINK_DIV (BD)
  ) dut (
    .clk_i     (clk_i),
    .rst       (rst),
    .bus       (bus.slave),
    .hex_led_o (hex_led_o),
    .hex_dp_o  (hex_dp_o),
    .hex_sel_o (hex_sel_o)
  );

  always #5 clk_i = ~clk_i;

  wire [DG+7:0] outs = {hex_sel_o, hex_led_o, hex_dp_o};

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [3:0]    m_val [DG];
  logic          m_dp [DG];
  logic [DG-1:0] m_en, m_blink;
  int            m_pos;
  logic [DG-1:0] e_sel;
  logic [6:0]    e_led;
  logic          e_dp;
  logic [31:0]   e_rd = '0;

  function automatic logic [DG+7:0] e_outs();
    return {e_sel, e_led, e_dp};
  endfunction

  function automatic int m_idx();
    return (m_pos / SD) % DG;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < DG; k++) begin
      m_val[k] = '0;
      m_dp[k] = 1'b0;
    end
    m_en = '1;
    m_blink = '0;
    m_pos = 0;
    e_sel = '1;
    e_led = 7'h7F;
    e_dp = 1'b1;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int k;
    if (a[1:0] != 2'b00) return '0;
    if (a < 32'(4 * DG)) begin
      k = int'(a[5:2]);
      return {27'd0, m_dp[k], m_val[k]};
    end
    if (a == 32'h40) return 32'(m_en);
    if (a == 32'h44) return 32'(m_blink);
    return '0;
  endfunction

  // One clock edge; the model computes what the outputs show after it
  task automatic tick();
    int slot, i, ph, k;
    logic vis, rq, we;
    logic [31:0] a, d;
    @(posedge clk_i);
    rq = bus.req_i;
    we = bus.write_enable_i;
    a = bus.addr_i;
    d = bus.write_data_i;
    if (rst) begin
      m_reset();
      e_rd = '0;
    end else begin
      slot = m_pos / SD;
      i = slot % DG;
      ph = (slot / DG / BD) % 2;
      vis = m_en[i] && !(m_blink[i] && ph == 1);
      e_sel = vis ? ~(DG'(1) << i) : '1;
      e_led = vis ? glyph[m_val[i]] : 7'h7F;
      e_dp = vis ? ~m_dp[i] : 1'b1;
      if (rq && !we) e_rd = m_read(a);
      if (rq && we && a == 32'h48 && d[0]) begin
        m_reset();
      end else begin
        if (rq && we) begin
          if (a[1:0] == 2'b00 && a < 32'(4 * DG)) begin
            k = int'(a[5:2]);
            m_val[k] = d[3:0];
            m_dp[k] = d[4];
          end else if (a == 32'h40) begin
            m_en = d[DG-1:0];
          end else if (a == 32'h44) begin
            m_blink = d[DG-1:0];
          end
        end
        m_pos++;
      end
    end
    #1;
  endtask

  task automatic idle();
    bus.req_i = 1'b0;
    bus.write_enable_i = 1'b0;
    bus.addr_i = '0;
    bus.write_data_i = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.req_i = 1'b1;
    bus.write_enable_i = 1'b1;
    bus.addr_i = a;
    bus.write_data_i = d;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.req_i = 1'b1;
    bus.write_enable_i = 1'b0;
    bus.addr_i = a;
    bus.write_data_i = $urandom;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (outs !== {4'hF, 7'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outs got %h exp %h", outs, {4'hF, 7'h7F, 1'b1});
    end
    n_tests++;
    if (bus.read_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata got %h exp 0", bus.read_data_o);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (outs !== {4'b1110, 7'h40, 1'b1}) begin
      n_fail++;
      $display("FAIL first_digit got %h exp %h", outs, {4'b1110, 7'h40, 1'b1});
    end
  endtask

  task automatic test_digit_write();
    wr(32'h08, 32'hFFFF_FF18);
    tick();
    idle();
    for (int c = 0; c < 2 * DG * SD; c++) begin
      tick();
      n_tests++;
      if (outs !== e_outs()) begin
        n_fail++;
        $display("FAIL digit_scan got %h exp %h", outs, e_outs());
      end
      if (e_sel == 4'b1011) begin
        n_tests++;
        if (outs !== {4'b1011, 7'h00, 1'b0}) begin
          n_fail++;
          $display("FAIL digit2_glyph got %h exp %h", outs, {4'b1011, 7'h00, 1'b0});
        end
      end
    end
  endtask

  task automatic test_read();
    logic [31:0] prev;
    prev = bus.read_data_o;
    rd(32'h08);
    n_tests++;
    if (bus.read_data_o !== prev) begin
      n_fail++;
      $display("FAIL read_early got %h exp %h", bus.read_data_o, prev);
    end
    tick();
    idle();
    n_tests++;
    if (bus.read_data_o !== 32'h18) begin
      n_fail++;
      $display("FAIL read_digit2 got %h exp 18", bus.read_data_o);
    end
    tick();
    n_tests++;
    if (bus.read_data_o !== 32'h18) begin
      n_fail++;
      $display("FAIL read_hold got %h exp 18", bus.read_data_o);
    end
    rd(32'h3C);
    tick();
    n_tests++;
    if (bus.read_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL read_3c got %h exp 0", bus.read_data_o);
    end
    rd(32'h08);
    tick();
    rd(32'h4A);
    tick();
    n_tests++;
    if (bus.read_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL read_4a got %h exp 0", bus.read_data_o);
    end
    rd(32'h08);
    tick();
    rd(32'h09);
    tick();
    idle();
    n_tests++;
    if (bus.read_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL read_misaligned got %h exp 0", bus.read_data_o);
    end
  endtask

  task automatic test_enable();
    wr(32'h40, 32'hFFFF_FFFE);
    tick();
    rd(32'h40);
    tick();
    idle();
    n_tests++;
    if (bus.read_data_o !== 32'hE) begin
      n_fail++;
      $display("FAIL read_en got %h exp e", bus.read_data_o);
    end
    for (int c = 0; c < 2 * DG * SD; c++) begin
      tick();
      n_tests++;
      if (outs !== e_outs()) begin
        n_fail++;
        $display("FAIL en_scan got %h exp %h", outs, e_outs());
      end
      if (e_sel == 4'hF) begin
        n_tests++;
        if (hex_led_o !== 7'h7F) begin
          n_fail++;
          $display("FAIL en_dark_led got %h exp 7f", hex_led_o);
        end
      end
    end
  endtask

  task automatic test_blink();
    int lit;
    lit = 0;
    wr(32'h40, 32'hF);
    tick();
    wr(32'h04, 32'h3);
    tick();
    wr(32'h44, 32'h1);
    tick();
    idle();
    tick();
    for (int c = 0; c < 2 * BD * DG * SD; c++) begin
      tick();
      if (hex_sel_o == 4'b1110) lit++;
      n_tests++;
      if (outs !== e_outs()) begin
        n_fail++;
        $display("FAIL blink_scan got %h exp %h", outs, e_outs());
      end
    end
    n_tests++;
    if (lit !== BD * SD) begin
      n_fail++;
      $display("FAIL blink_duty got %0d exp %0d", lit, BD * SD);
    end
  endtask

  task automatic test_soft_reset();
    wr(32'h44, 32'h2);
    tick();
    wr(32'h0C, 32'h17);
    tick();
    rd(32'h0C);
    tick();
    idle();
    for (int c = 0; c < 64 && m_idx() != 3; c++) tick();
    n_tests++;
    if (m_idx() != 3) begin
      n_fail++;
      $display("FAIL soft_wait got %0d exp 3", m_idx());
    end
    tick();
    wr(32'h48, 32'h1);
    tick();
    idle();
    n_tests++;
    if (outs !== {4'hF, 7'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL soft_outs got %h exp %h", outs, {4'hF, 7'h7F, 1'b1});
    end
    n_tests++;
    if (bus.read_data_o !== 32'h17) begin
      n_fail++;
      $display("FAIL soft_rdata got %h exp 17", bus.read_data_o);
    end
    tick();
    n_tests++;
    if (outs !== {4'b1110, 7'h40, 1'b1}) begin
      n_fail++;
      $display("FAIL soft_restart got %h exp %h", outs, {4'b1110, 7'h40, 1'b1});
    end
    rd(32'h0C);
    tick();
    n_tests++;
    if (bus.read_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL soft_digit got %h exp 0", bus.read_data_o);
    end
    rd(32'h40);
    tick();
    n_tests++;
    if (bus.read_data_o !== 32'hF) begin
      n_fail++;
      $display("FAIL soft_en got %h exp f", bus.read_data_o);
    end
    rd(32'h44);
    tick();
    n_tests++;
    if (bus.read_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL soft_blink got %h exp 0", bus.read_data_o);
    end
    wr(32'h04, 32'h15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd(32'h04);
    tick();
    idle();
    n_tests++;
    if (bus.read_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_beats_write got %h exp 0", bus.read_data_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v, a;
    for (int r = 0; r < 8; r++) begin
      v = 32'($urandom_range(0, 31));
      a = 32'($urandom_range(0, DG - 1)) << 2;
      wr(a, v | 32'hABCD_0000);
      tick();
      rd(a);
      tick();
      idle();
      n_tests++;
      if (bus.read_data_o !== v) begin
        n_fail++;
        $display("FAIL b2b_read got %h exp %h", bus.read_data_o, v);
      end
    end
  endtask

  task automatic test_random();
    int sel;
    logic [31:0] a;
    for (int c = 0; c < 800; c++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1, 2, 3: a = 32'(sel) << 2;
        4: a = 32'h40;
        5: a = 32'h44;
        6: a = $urandom & 32'hFF;
        default: a = ($urandom_range(0, 19) == 0) ? 32'h48 : 32'h3C;
      endcase
      bus.req_i = $urandom_range(0, 3) != 0;
      bus.write_enable_i = 1'($urandom);
      bus.addr_i = a;
      bus.write_data_i = $urandom;
      tick();
      n_tests++;
      if (outs !== e_outs()) begin
        n_fail++;
        $display("FAIL rand_outs got %h exp %h", outs, e_outs());
      end
      n_tests++;
      if (bus.read_data_o !== e_rd) begin
        n_fail++;
        $display("FAIL rand_rdata got %h exp %h", bus.read_data_o, e_rd);
      end
    end
    idle();
  endtask

  initial begin
    m_reset();
    test_reset();
    test_digit_write();
    test_read();
    test_enable();
    test_blink();
    test_soft_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
